// File: rtl/logic_result_buffer.sv
// -----------------------------------------------------------------------------
// logic_result_buffer
//
// Purpose:
//   Sits after the 32-bit bitwise logic unit (XOR/AND/OR). Each accepted result
//   is stored with its destination register tag and three status flags:
//   zero, negative and odd parity. The flags are computed when the result is
//   written. The entries sit in a small FIFO. The head entry goes to the
//   writeback stage, so writeback stalls do not stall the logic unit.
//
// Handshake (both sides):
//   A transfer happens on a rising clock edge where valid && ready are both
//   high. valid must not depend on ready. The producer holds its payload while
//   valid && !ready. The payload of an un-accepted cycle is ignored.
//   in_ready  = !full.  It never looks at out_ready. When the buffer is full,
//                      a pop in the same cycle does not open a push slot.
//   out_valid = !empty. When empty, out_ready is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; release is synchronous upstream
//   in_valid   logic unit presents a result
//   in_ready   buffer can accept (not full)
//   in_data    result word
//   in_tag     destination register number
//   out_valid  head entry available (not empty)
//   out_ready  writeback consumes the head entry
//   out_data   head result word (0 when empty)
//   out_tag    head destination tag (0 when empty)
//   out_zero   head result == 0
//   out_neg    head result sign bit
//   out_par    XOR-reduction of the head result (1 = odd number of ones)
//   count      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module logic_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int TAGW  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [TAGW-1:0]            in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [TAGW-1:0]            out_tag,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic                       out_par,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);
  localparam logic [PTRW-1:0] PTR_ONE    = PTRW'(1);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);

  // Flag bit positions inside each stored flag triple.
  localparam int F_ZERO = 0;
  localparam int F_NEG  = 1;
  localparam int F_PAR  = 2;

  // ---------------------------------------------------------------------------
  // Entry storage. Reset does not clear it. The outputs are masked while the
  // buffer is empty, so stale entries never reach the output pins.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_data  [DEPTH];
  logic [TAGW-1:0]  mem_tag   [DEPTH];
  logic [2:0]       mem_flags [DEPTH];

  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [CNTW-1:0]  count_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [2:0]       in_flags;

  // ---------------------------------------------------------------------------
  // Status derived only from occupancy. Pointer equality is ambiguous when
  // the pointers wrap.
  // ---------------------------------------------------------------------------
  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Flags are a pure function of the word. They are computed at write time,
  // so no reduction logic sits on the writeback-facing output path.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_flags         = '0;
    in_flags[F_ZERO] = ~|in_data;
    in_flags[F_NEG]  = in_data[WIDTH-1];
    in_flags[F_PAR]  = ^in_data;
  end

  // ---------------------------------------------------------------------------
  // Entry write. There is no reset, because the contents are don't-care
  // until the entry is pushed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= in_data;
      mem_tag[wr_ptr]   <= in_tag;
      mem_flags[wr_ptr] <= in_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers. They are PTRW bits wide and DEPTH is a power of two, so they
  // wrap from DEPTH-1 to 0 on their own.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy. A push and a pop in the same cycle cancel each other.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation. The outputs come only from storage and state, with no
  // path from in_*. They are gated by out_valid, so they read 0 while empty.
  // Because count resets asynchronously, the outputs also clear as soon as
  // rst_n asserts.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data = '0;
    out_tag  = '0;
    out_zero = 1'b0;
    out_neg  = 1'b0;
    out_par  = 1'b0;
    if (out_valid) begin
      out_data = mem_data[rd_ptr];
      out_tag  = mem_tag[rd_ptr];
      out_zero = mem_flags[rd_ptr][F_ZERO];
      out_neg  = mem_flags[rd_ptr][F_NEG];
      out_par  = mem_flags[rd_ptr][F_PAR];
    end
  end

endmodule

// File: doc/logic_result_buffer.md
Name: logic_result_buffer

Overview:
- Downstream stage of the 32-bit bitwise logic unit (XOR/AND/OR results).
- Captures each result with its destination register tag and computes status flags: zero, negative, odd parity.
- Holds results in a small FIFO and presents them to the writeback stage over a valid/ready handshake, decoupling logic-unit issue from writeback stalls.

Parameters:
- WIDTH, 32, data width of the result word.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- TAGW, 5, width of the destination register tag.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  logic unit presents a result this cycle.
- in_ready  output  1  buffer can accept; equals not full.
- in_data  input  WIDTH  result word from the logic unit.
- in_tag  input  TAGW  destination register number.
- out_valid  output  1  head entry available; equals not empty.
- out_ready  input  1  writeback consumes the head entry.
- out_data  output  WIDTH  head result word.
- out_tag  output  TAGW  head destination tag.
- out_zero  output  1  head result == 0.
- out_neg  output  1  bit WIDTH-1 of head result.
- out_par  output  1  XOR-reduction of head result (1 = odd number of ones).
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr and count go to 0.
  - out_valid = 0 and in_ready = 1.
  - out_data, out_tag and out flags = 0.
  - Entry storage need not be cleared.
- Push occurs when in_valid && in_ready.
  - data, tag and the three flags are computed combinationally from in_data and stored in the entry at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid && out_ready; rd_ptr increments modulo DEPTH.
- Outputs are driven from the entry at rd_ptr. They are registered/storage-based with no combinational path from in_* to out_*.
- Latency: a result pushed in cycle N is visible on out_* with out_valid = 1 in cycle N+1 at the earliest.
- No bypass when empty: push and pop cannot refer to the same entry in one cycle.
- count updates:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Boundary conditions:
  - Full (count == DEPTH): in_ready = 0 even if out_ready = 1 in the same cycle. No simultaneous push on the pop cycle; this keeps in_ready free of combinational dependence on out_ready.
  - Empty (count == 0): out_valid = 0, and out_ready is ignored.
  - Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full/empty are derived from count, never from pointer equality.
- Holding rules:
  - out_* stay stable while out_valid = 1 and out_ready = 0.
  - in_data/in_tag are ignored when in_ready = 0; the producer must hold them.
- Reset asserted mid-operation discards all entries immediately; out_valid drops asynchronously.
- Flags are a pure function of the stored word:
  - out_zero = ~|data
  - out_neg = data[WIDTH-1]
  - out_par = ^data

Test Plan:
- Reset: hold rst_n = 0, drive in_valid = 1 -> in_ready = 1, out_valid = 0, count = 0. No entry written until release.
- Single transfer: push data 0x8000_0001, tag 5 with out_ready = 0 -> next cycle out_valid = 1, out_data = 0x80000001, out_tag = 5, out_zero = 0, out_neg = 1, out_par = 0, count = 1.
- Zero flag: push 0x0000_0000 (e.g. A xor A) -> out_zero = 1, out_neg = 0, out_par = 0. Then push 0x0000_0007 -> out_par = 1 once it reaches the head.
- Fill and backpressure: out_ready = 0, push 0x11, 0x22, 0x33, 0x44 -> count = 4 and in_ready = 0. A fifth push of 0x55 is not accepted. Raise out_ready for 4 cycles -> outputs 0x11, 0x22, 0x33, 0x44 in order, then count = 0.
- Streaming with wrap: in_valid = out_ready = 1 continuously for 10 words 1..10 -> every word emitted in order exactly once, count never exceeds 1, pointers wrap without loss.
- Reset mid-operation: with count = 3, pulse rst_n low for a partial cycle -> out_valid falls immediately and count = 0. After release, a new push 0xABCD appears as the first output.
